seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 21 ++
 rtl/seq_divider_csa.sv | 27 ++
 rtl/seq_divider.sv | 123 ++++++++++++
 tb/tb_seq_divider.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width, FSM states and
// iteration-counter sizing.
package seq_divider_pkg;

  localparam int unsigned DefWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  // Bits needed to count 0 .. n-1 iterations.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CntW = cnt_width(DefWidth);

endpackage

// File: rtl/seq_divider_csa.sv
// Carry-select adder: low half ripples, high half is precomputed for both carries and selected.
module seq_divider_csa #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned Lo = WIDTH / 2;
  localparam int unsigned Hi = WIDTH - Lo;

  logic [Lo:0] lo_sum;
  logic [Hi:0] hi_sum0, hi_sum1, hi_sel;

  always_comb begin
    lo_sum  = {1'b0, x[Lo-1:0]} + {1'b0, y[Lo-1:0]} + {{Lo{1'b0}}, cin};
    hi_sum0 = {1'b0, x[WIDTH-1:Lo]} + {1'b0, y[WIDTH-1:Lo]};
    hi_sum1 = {1'b0, x[WIDTH-1:Lo]} + {1'b0, y[WIDTH-1:Lo]} + {{Hi{1'b0}}, 1'b1};
    hi_sel  = lo_sum[Lo] ? hi_sum1 : hi_sum0;
    sum     = {hi_sel[Hi-1:0], lo_sum[Lo-1:0]};
    cout    = hi_sel[Hi];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, with signed/unsigned modes,
// divide-by-zero and signed-overflow flags.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned CALC_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = cnt_width(CALC_CYCLES);
  localparam logic [CW-1:0] LastCnt = CW'(CALC_CYCLES - 1);

  div_state_e state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic             q_neg_q, r_neg_q, ovf_q;

  logic             a_neg, b_neg, is_ovf, nonneg, unused_diff_msb;
  logic [WIDTH-1:0] mag_a, mag_b, rem_next;
  logic [WIDTH:0]   trial, diff;

  always_comb begin
    a_neg    = signed_op & a[WIDTH-1];
    b_neg    = signed_op & b[WIDTH-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    is_ovf   = signed_op && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    // Partial remainder is below the divisor, so one extra bit holds the shifted trial value.
    trial    = {rem_q, dvd_q[WIDTH-1]};
    rem_next = nonneg ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  seq_divider_csa #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .x   (trial),
    .y   (~{1'b0, dvs_q}),
    .cin (1'b1),
    .sum (diff),
    .cout(nonneg)
  );

  assign unused_diff_msb = diff[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ovf_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (b == '0) begin
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              done        <= 1'b1;
              state_q     <= StDone;
            end else begin
              dvd_q   <= mag_a;
              dvs_q   <= mag_b;
              rem_q   <= '0;
              quo_q   <= '0;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              ovf_q   <= is_ovf;
              cnt_q   <= '0;
              busy    <= 1'b1;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[WIDTH-2:0], nonneg};
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_q <= StFix;
        end
        StFix: begin
          quotient    <= q_neg_q ? -quo_q : quo_q;
          remainder   <= r_neg_q ? -rem_q : rem_q;
          div_by_zero <= 1'b0;
          overflow    <= ovf_q;
          busy        <= 1'b0;
          done        <= 1'b1;
          state_q     <= StDone;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands checked
// against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  localparam int NormLat = 33;  // edges after the accepting edge until done is visible

  seq_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint sx, sy, lq, lr;
    logic [31:0] q, r;
    logic dz, ov;
    dz = 1'b0;
    ov = 1'b0;
    if (y == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = x;
      dz = 1'b1;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      lq = sx / sy;
      lr = sx % sy;
      q  = lq[31:0];
      r  = lr[31:0];
      ov = (sx == -64'sd2147483648) && (sy == -64'sd1);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {q, r, dz, ov};
  endfunction

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                        output int lat, output logic busy_err);
    @(negedge clk);
    a = ia; b = ib; signed_op = is; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; signed_op = 1'($urandom);
    lat = 0;
    busy_err = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_err = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) busy_err = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h dz=%b ov=%b want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic run_and_check(input string name, input logic [31:0] ia, input logic [31:0] ib,
                               input logic is);
    int lat, exp_lat;
    logic busy_err;
    logic [65:0] exp;
    exp = ref_div(ia, ib, is);
    exp_lat = (ib == 32'd0) ? 0 : NormLat;
    run_op(ia, ib, is, lat, busy_err);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== exp) begin
      failures++;
      $display("FAIL %s a=%h b=%h s=%b got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
               name, ia, ib, is, quotient, remainder, div_by_zero, overflow,
               exp[65:34], exp[33:2], exp[1], exp[0]);
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency a=%h b=%h got %0d want %0d", name, ia, ib, lat, exp_lat);
    end
    checks++;
    if (busy_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy a=%h b=%h got busy error want none", name, ia, ib);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse got done=%b want 0", name, done);
    end
  endtask

  task automatic test_directed();
    run_and_check("unsigned_100_7", 32'd100, 32'd7, 1'b0);
    run_and_check("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_and_check("div_zero_u", 32'd5, 32'd0, 1'b0);
    run_and_check("div_zero_s", 32'd5, 32'd0, 1'b1);
    run_and_check("signed_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_and_check("unsigned_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_and_check("signed_neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = ra ^ 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      run_and_check("random", ra, rb, 1'($urandom));
    end
  endtask

  task automatic test_start_ignored();
    logic [65:0] exp;
    logic [31:0] q0;
    int first_k, n_done;
    logic held_ok;
    exp = ref_div(32'hFFFF_FFFF, 32'h10, 1'b0);
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h10; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    q0 = quotient;
    a = 32'd1; b = 32'd1; signed_op = 1'b1;
    first_k = -1; n_done = 0; held_ok = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      start = (k == 5);
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (first_k < 0) first_k = k;
      end
      if (first_k < 0 && quotient !== q0) held_ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (first_k !== NormLat || n_done !== 1) begin
      failures++;
      $display("FAIL start_ignored_done got first=%0d count=%0d want %0d 1",
               first_k, n_done, NormLat);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== exp) begin
      failures++;
      $display("FAIL start_ignored_result got q=%h r=%h want q=%h r=%h",
               quotient, remainder, exp[65:34], exp[33:2]);
    end
    checks++;
    if (held_ok !== 1'b1) begin
      failures++;
      $display("FAIL quotient_held got change during calc want stable %h", q0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic s1, s2;
    logic [65:0] r1, r2;
    int k1, k2, n_done;
    a1 = $urandom; b1 = ($urandom % 1000) + 1; s1 = 1'($urandom);
    a2 = $urandom; b2 = $urandom | 32'h1;      s2 = 1'($urandom);
    r1 = '0; r2 = '0; k1 = -1; k2 = -1; n_done = 0;
    @(negedge clk);
    a = a1; b = b1; signed_op = s1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 80; k++) begin
      if (k == 34) begin a = a2; b = b2; signed_op = s2; end
      start = (k <= 35);
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin
          k1 = k; r1 = {quotient, remainder, div_by_zero, overflow};
        end else begin
          k2 = k; r2 = {quotient, remainder, div_by_zero, overflow};
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n_done !== 2 || k1 !== NormLat || k2 !== NormLat + 35) begin
      failures++;
      $display("FAIL back_to_back_timing got count=%0d k1=%0d k2=%0d want 2 %0d %0d",
               n_done, k1, k2, NormLat, NormLat + 35);
    end
    checks++;
    if (r1 !== ref_div(a1, b1, s1)) begin
      failures++;
      $display("FAIL back_to_back_first got %h want %h", r1, ref_div(a1, b1, s1));
    end
    checks++;
    if (r2 !== ref_div(a2, b2, s2)) begin
      failures++;
      $display("FAIL back_to_back_second got %h want %h", r2, ref_div(a2, b2, s2));
    end
  endtask

  task automatic test_mid_reset();
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got busy=%b done=%b q=%h r=%h dz=%b ov=%b want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_done got done pulse want none");
    end
    run_and_check("after_reset_9_3", 32'd9, 32'd3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
